uart_peripheral: RTL and testbench

- Memory-mapped 8N1 UART slave on the shared CPU data bus. It sits beside simple_ram and is selected by the external device_select decode; CPU high address byte 0xF0 maps here.
- The CPU enables it through CR, polls SR.TXR/RXR, writes DO to transmit and reads DI to receive.
- Single-byte TX holding register plus TX shift register; single-byte RX data register.

---
 rtl/uart_peripheral_pkg.sv | 10 +
 rtl/global_defines.sv | 16 +
 rtl/uart_rx_core.sv | 77 +++++++
 rtl/uart_peripheral.sv | 134 +++++++++++++
 tb/tb_uart_peripheral.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_peripheral_pkg.sv
// uart_peripheral_pkg: shared FSM state type and baud helper for the UART peripheral
package uart_peripheral_pkg;
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;
  // Down-counter load so the start-bit check lands (DIV+1)/2 cycles after the edge
  function automatic logic [15:0] half_wait(input logic [15:0] div);
    logic [16:0] h;
    h = ({1'b0, div} + 17'd1) >> 1;
    return (h == 17'd0) ? 16'd0 : 16'(h - 17'd1);
  endfunction
endpackage

// File: rtl/global_defines.sv
// global_defines: UART register offsets and bit positions shared with CPU test programs
`ifndef GLOBAL_DEFINES_SV
`define GLOBAL_DEFINES_SV
`define UART_CR      3'd0
`define UART_SR      3'd1
`define UART_DIVL    3'd2
`define UART_DIVH    3'd3
`define UART_DI      3'd4
`define UART_DO      3'd5
`define UART_CR_RXEN 0
`define UART_CR_TXEN 1
`define UART_SR_RXR  0
`define UART_SR_TXR  1
`define UART_SR_OVR  2
`define UART_SR_FE   3
`endif

// File: rtl/uart_rx_core.sv
// uart_rx_core: rxd synchroniser, receive FSM and shift register emitting one-cycle byte strobes
module uart_rx_core
  import uart_peripheral_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  input  logic        en,
  input  logic [15:0] div,
  output logic        byte_valid,
  output logic [7:0]  data,
  output logic        frame_err
);
  logic s1, s2, s3;
  uart_state_t state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] sh, sh_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= rxd;
      s2 <= s1;
      s3 <= s2;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt <= 16'd0;
      idx <= 3'd0;
      sh <= 8'd0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      sh <= sh_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt - 16'd1;
    idx_n = idx;
    sh_n = sh;
    byte_valid = 1'b0;
    frame_err = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_n = half_wait(div);
        state_n = (s3 && !s2) ? S_START : S_IDLE;
      end
      S_START: if (cnt == 16'd0) begin
        state_n = s2 ? S_IDLE : S_DATA;
        cnt_n = div;
        idx_n = 3'd0;
      end
      S_DATA: if (cnt == 16'd0) begin
        sh_n = {s2, sh[7:1]};
        cnt_n = div;
        idx_n = idx + 3'd1;
        state_n = (idx == 3'd7) ? S_STOP : S_DATA;
      end
      S_STOP: if (cnt == 16'd0) begin
        state_n = S_IDLE;
        byte_valid = en;
        frame_err = !s2;
      end
      default: state_n = S_IDLE;
    endcase
    // Dropping RXEN abandons any partial frame
    if (!en) state_n = S_IDLE;
  end
  assign data = sh;
endmodule

// File: rtl/uart_peripheral.sv
// uart_peripheral: memory-mapped 8N1 UART slave with register file, bus decode and TX FSM
`include "global_defines.sv"
module uart_peripheral
  import uart_peripheral_pkg::*;
#(
  parameter logic [2:0]  DEVICE_ADDRESS = 3'b111,
  parameter logic [15:0] DEFAULT_DIV    = 16'd103
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  device_select,
  input  logic [15:0] addr_in,
  input  logic        we,
  input  logic        oe,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  input  logic        rxd,
  output logic        txd
);
  logic sel, wr, rd_di, unused_addr;
  logic [2:0] a;
  logic [1:0] cr;
  logic txr, rxr, ovr, fe;
  logic [15:0] div;
  logic [7:0] di, hold, rd_data;
  uart_state_t tx_state, tx_state_n;
  logic [15:0] tx_cnt, tx_cnt_n;
  logic [2:0] tx_bit, tx_bit_n;
  logic [7:0] tx_sh, tx_sh_n;
  logic txd_n, tx_load;
  logic rx_valid, rx_fe;
  logic [7:0] rx_data;
  assign a = addr_in[2:0];
  assign unused_addr = ^addr_in[15:3];
  assign sel = device_select == DEVICE_ADDRESS;
  assign wr = we && sel;
  assign rd_di = oe && sel && a == `UART_DI;
  always_comb begin
    rd_data = (a == `UART_CR)   ? {6'd0, cr} :
              (a == `UART_SR)   ? {4'd0, fe, ovr, txr, rxr} :
              (a == `UART_DIVL) ? div[7:0] :
              (a == `UART_DIVH) ? div[15:8] :
              (a == `UART_DI)   ? di : 8'h00;
  end
  assign data_out = (oe && sel) ? rd_data : 8'hzz;
  // A same-cycle delivery overrides the RXR clear from a DI read
  always_ff @(posedge clk) begin
    if (rst) begin
      cr <= 2'd0;
      txr <= 1'b1;
      rxr <= 1'b0;
      ovr <= 1'b0;
      fe <= 1'b0;
      div <= DEFAULT_DIV;
      di <= 8'd0;
      hold <= 8'd0;
    end else begin
      if (wr && a == `UART_CR) cr <= data_in[1:0];
      if (wr && a == `UART_SR && data_in[`UART_SR_OVR]) ovr <= 1'b0;
      if (wr && a == `UART_SR && data_in[`UART_SR_FE]) fe <= 1'b0;
      if (wr && a == `UART_DIVL) div[7:0] <= data_in;
      if (wr && a == `UART_DIVH) div[15:8] <= data_in;
      if (wr && a == `UART_DO && txr) begin
        hold <= data_in;
        txr <= 1'b0;
      end
      if (tx_load) txr <= 1'b1;
      if (rd_di) rxr <= 1'b0;
      if (rx_valid) begin
        if (!rxr) di <= rx_data;
        if (rxr) ovr <= 1'b1;
        if (rx_fe) fe <= 1'b1;
        rxr <= 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= S_IDLE;
      tx_cnt <= 16'd0;
      tx_bit <= 3'd0;
      tx_sh <= 8'd0;
      txd <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt <= tx_cnt_n;
      tx_bit <= tx_bit_n;
      tx_sh <= tx_sh_n;
      txd <= txd_n;
    end
  end
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n = tx_cnt - 16'd1;
    tx_bit_n = tx_bit;
    tx_sh_n = tx_sh;
    txd_n = txd;
    tx_load = 1'b0;
    case (tx_state)
      S_IDLE: begin
        tx_cnt_n = div;
        tx_load = cr[`UART_CR_TXEN] && !txr;
        tx_sh_n = tx_load ? hold : tx_sh;
        txd_n = !tx_load;
        tx_state_n = tx_load ? S_START : S_IDLE;
      end
      S_START: if (tx_cnt == 16'd0) begin
        tx_cnt_n = div;
        tx_bit_n = 3'd0;
        txd_n = tx_sh[0];
        tx_state_n = S_DATA;
      end
      S_DATA: if (tx_cnt == 16'd0) begin
        tx_cnt_n = div;
        tx_sh_n = tx_sh >> 1;
        tx_bit_n = tx_bit + 3'd1;
        txd_n = (tx_bit == 3'd7) ? 1'b1 : tx_sh[1];
        tx_state_n = (tx_bit == 3'd7) ? S_STOP : S_DATA;
      end
      S_STOP: if (tx_cnt == 16'd0) tx_state_n = S_IDLE;
      default: tx_state_n = S_IDLE;
    endcase
  end
  uart_rx_core u_rx (
    .clk(clk),
    .rst(rst),
    .rxd(rxd),
    .en(cr[`UART_CR_RXEN]),
    .div(div),
    .byte_valid(rx_valid),
    .data(rx_data),
    .frame_err(rx_fe)
  );
endmodule

// File: tb/tb_uart_peripheral.sv
// tb_uart_peripheral: randomized self-checking bench against a frame-level UART reference model
module tb_uart_peripheral;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] device_select = 3'd0;
  logic [15:0] addr_in = 16'd0;
  logic we = 1'b0;
  logic oe = 1'b0;
  logic [7:0] data_in = 8'd0;
  tri1 [7:0] data_out;
  logic rxd = 1'b1;
  logic txd;
  int total = 0;
  int passed = 0;
  bit rec = 1'b0;
  logic txq[$];
  logic [7:0] di_m;
  logic rxr_m, ovr_m, fe_m;
  logic [7:0] exp_rst [8] = '{8'h00, 8'h02, 8'h67, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  uart_peripheral dut (
    .clk(clk), .rst(rst), .device_select(device_select), .addr_in(addr_in),
    .we(we), .oe(oe), .data_in(data_in), .data_out(data_out), .rxd(rxd), .txd(txd)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (rec) txq.push_back(txd);

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    device_select = 3'b111; addr_in = {8'hF0, 5'd0, a}; data_in = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0; device_select = 3'd0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk);
    device_select = 3'b111; addr_in = {8'hF0, 5'd0, a}; oe = 1'b1;
    #1 d = data_out;
    @(negedge clk);
    oe = 1'b0; device_select = 3'd0;
  endtask

  task automatic peek(input logic [2:0] a, output logic [7:0] d);
    device_select = 3'b111; addr_in = {8'hF0, 5'd0, a}; oe = 1'b1;
    #1 d = data_out;
    oe = 1'b0; device_select = 3'd0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop, input int p);
    for (int k = 0; k < 10; k++) begin
      rxd = (k == 0) ? 1'b0 : (k == 9) ? stop : b[k-1];
      repeat (p) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (2 * p) @(negedge clk);
  endtask

  task automatic model_rx(input logic [7:0] b, input logic stop);
    if (!stop) fe_m = 1'b1;
    if (rxr_m) ovr_m = 1'b1;
    else begin
      di_m = b;
      rxr_m = 1'b1;
    end
  endtask

  task automatic test_reset;
    logic [7:0] d;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus_read(3'(i), d);
      total++;
      if (d !== exp_rst[i]) $display("FAIL reset_reg[%0d]: got %h expected %h", i, d, exp_rst[i]);
      else passed++;
    end
    total++;
    if (txd !== 1'b1) $display("FAIL reset_txd: got %b expected 1", txd); else passed++;
    @(negedge clk);
    device_select = 3'($urandom_range(0, 6)); addr_in = 16'hF001; oe = 1'b1;
    #1 total++;
    if (data_out !== 8'hzz && data_out !== 8'hff) $display("FAIL hiz_deselected: got %h expected zz", data_out);
    else passed++;
    device_select = 3'b111; oe = 1'b0;
    #1 total++;
    if (data_out !== 8'hzz && data_out !== 8'hff) $display("FAIL hiz_no_oe: got %h expected zz", data_out);
    else passed++;
    device_select = 3'd0;
  endtask

  task automatic test_regs;
    logic [7:0] d, lo, hi;
    bus_write(3'd0, 8'hFF);
    bus_read(3'd0, d);
    total++;
    if (d !== 8'h03) $display("FAIL cr_mask: got %h expected 03", d); else passed++;
    bus_write(3'd0, 8'h00);
    lo = 8'($urandom); hi = 8'($urandom);
    bus_write(3'd2, lo); bus_write(3'd3, hi);
    bus_read(3'd2, d);
    total++;
    if (d !== lo) $display("FAIL divl_rw: got %h expected %h", d, lo); else passed++;
    bus_read(3'd3, d);
    total++;
    if (d !== hi) $display("FAIL divh_rw: got %h expected %h", d, hi); else passed++;
    bus_write(3'd1, 8'h03);
    bus_write(3'd6, 8'($urandom)); bus_write(3'd7, 8'($urandom));
    bus_read(3'd1, d);
    total++;
    if (d !== 8'h02) $display("FAIL sr_readonly: got %h expected 02", d); else passed++;
    bus_read(3'd6, d);
    total++;
    if (d !== 8'h00) $display("FAIL reg6: got %h expected 00", d); else passed++;
    bus_read(3'd7, d);
    total++;
    if (d !== 8'h00) $display("FAIL reg7: got %h expected 00", d); else passed++;
  endtask

  task automatic test_tx_frame(input logic [7:0] b);
    logic [9:0] fr;
    logic [7:0] d;
    fr = {1'b1, b, 1'b0};
    bus_write(3'd2, 8'd3); bus_write(3'd3, 8'd0); bus_write(3'd0, 8'h03);
    repeat (2) @(negedge clk);
    bus_write(3'd5, b);
    peek(3'd1, d);
    total++;
    if (d[1] !== 1'b0 || txd !== 1'b1) $display("FAIL tx_after_write %h: txr=%b txd=%b expected 0,1", b, d[1], txd);
    else passed++;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) begin
        peek(3'd1, d);
        total++;
        if (d[1] !== 1'b1) $display("FAIL tx_txr_return %h: got %b expected 1", b, d[1]); else passed++;
      end
      total++;
      if (txd !== fr[i/4]) $display("FAIL tx_cell[%0d] %h: got %b expected %b", i, b, txd, fr[i/4]);
      else passed++;
    end
    repeat (4) @(negedge clk);
    total++;
    if (txd !== 1'b1) $display("FAIL tx_idle_after %h: got %b expected 1", b, txd); else passed++;
  endtask

  task automatic test_back_to_back;
    logic [7:0] a, b, c, d, v;
    int starts[$];
    logic [7:0] got[$];
    int i, p;
    p = 4;
    a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
    txq.delete();
    rec = 1'b1;
    bus_write(3'd5, a);
    bus_write(3'd5, b);
    bus_write(3'd5, c);
    peek(3'd1, d);
    total++;
    if (d[1] !== 1'b0) $display("FAIL b2b_txr_full: got %b expected 0", d[1]); else passed++;
    repeat (110) @(negedge clk);
    rec = 1'b0;
    i = 1;
    while (i < txq.size()) begin
      if (txq[i] === 1'b0 && txq[i-1] === 1'b1) begin
        if (i + 9 * p + p / 2 >= txq.size()) break;
        for (int k = 0; k < 8; k++) v[k] = txq[i + (k + 1) * p + p / 2];
        starts.push_back(i);
        got.push_back(v);
        i += 9 * p + p / 2 + 1;
      end else i++;
    end
    total++;
    if (got.size() != 2) $display("FAIL b2b_frame_count: got %0d expected 2", got.size()); else passed++;
    total++;
    if ((got.size() > 0 ? got[0] : 8'hxx) !== a) $display("FAIL b2b_first: got %h expected %h", got.size() > 0 ? got[0] : 8'hxx, a);
    else passed++;
    total++;
    if ((got.size() > 1 ? got[1] : 8'hxx) !== b) $display("FAIL b2b_second: got %h expected %h", got.size() > 1 ? got[1] : 8'hxx, b);
    else passed++;
    total++;
    if (starts.size() < 2 || starts[1] - starts[0] < 10 * p || starts[1] - starts[0] > 10 * p + 1)
      $display("FAIL b2b_gap: got %0d expected %0d or %0d", starts.size() > 1 ? starts[1] - starts[0] : -1, 10 * p, 10 * p + 1);
    else passed++;
    peek(3'd1, d);
    total++;
    if (d[1] !== 1'b1) $display("FAIL b2b_txr_end: got %b expected 1", d[1]); else passed++;
  endtask

  task automatic test_reset_mid_tx;
    logic [7:0] d;
    int lows;
    bus_write(3'd5, 8'h00);
    repeat (15) @(negedge clk);
    total++;
    if (txd !== 1'b0) $display("FAIL rst_pre_txd: got %b expected 0", txd); else passed++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (txd !== 1'b1) $display("FAIL rst_txd: got %b expected 1", txd); else passed++;
    bus_read(3'd1, d);
    total++;
    if (d !== 8'h02) $display("FAIL rst_sr: got %h expected 02", d); else passed++;
    bus_read(3'd2, d);
    total++;
    if (d !== 8'h67) $display("FAIL rst_divl: got %h expected 67", d); else passed++;
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    total++;
    if (lows != 0) $display("FAIL rst_no_resume: got %0d low cycles expected 0", lows); else passed++;
  endtask

  task automatic test_rx;
    logic [7:0] d, b;
    bus_write(3'd2, 8'd7); bus_write(3'd3, 8'd0); bus_write(3'd0, 8'h01);
    rxr_m = 1'b0; ovr_m = 1'b0; fe_m = 1'b0; di_m = 8'h00;
    send_rx(8'h55, 1'b1, 8); model_rx(8'h55, 1'b1);
    send_rx(8'hA3, 1'b1, 8); model_rx(8'hA3, 1'b1);
    bus_read(3'd1, d);
    total++;
    if (d !== {4'd0, fe_m, ovr_m, 1'b1, rxr_m}) $display("FAIL rx_overrun_sr: got %h expected %h", d, {4'd0, fe_m, ovr_m, 1'b1, rxr_m});
    else passed++;
    peek(3'd4, d);
    total++;
    if (d !== di_m) $display("FAIL rx_overrun_di: got %h expected %h", d, di_m); else passed++;
    bus_write(3'd1, 8'h04); ovr_m = 1'b0;
    bus_read(3'd1, d);
    total++;
    if (d !== {4'd0, fe_m, ovr_m, 1'b1, rxr_m}) $display("FAIL rx_ovr_clear: got %h expected %h", d, {4'd0, fe_m, ovr_m, 1'b1, rxr_m});
    else passed++;
    bus_read(3'd4, d); rxr_m = 1'b0;
    total++;
    if (d !== di_m) $display("FAIL rx_di_read: got %h expected %h", d, di_m); else passed++;
    bus_read(3'd1, d);
    total++;
    if (d !== {4'd0, fe_m, ovr_m, 1'b1, rxr_m}) $display("FAIL rx_rxr_clear: got %h expected %h", d, {4'd0, fe_m, ovr_m, 1'b1, rxr_m});
    else passed++;
    send_rx(8'h3C, 1'b0, 8); model_rx(8'h3C, 1'b0);
    bus_read(3'd1, d);
    total++;
    if (d !== {4'd0, fe_m, ovr_m, 1'b1, rxr_m}) $display("FAIL rx_fe_sr: got %h expected %h", d, {4'd0, fe_m, ovr_m, 1'b1, rxr_m});
    else passed++;
    bus_read(3'd4, d); rxr_m = 1'b0;
    total++;
    if (d !== di_m) $display("FAIL rx_fe_di: got %h expected %h", d, di_m); else passed++;
    bus_write(3'd1, 8'h08); fe_m = 1'b0;
    @(negedge clk) rxd = 1'b0;
    @(negedge clk) rxd = 1'b1;
    repeat (40) @(negedge clk);
    bus_read(3'd1, d);
    total++;
    if (d !== {4'd0, fe_m, ovr_m, 1'b1, rxr_m}) $display("FAIL rx_glitch: got %h expected %h", d, {4'd0, fe_m, ovr_m, 1'b1, rxr_m});
    else passed++;
    for (int n = 0; n < 3; n++) begin
      b = 8'($urandom);
      send_rx(b, 1'b1, 8); model_rx(b, 1'b1);
      bus_read(3'd4, d); rxr_m = 1'b0;
      total++;
      if (d !== di_m) $display("FAIL rx_random[%0d]: got %h expected %h", n, d, di_m); else passed++;
      bus_read(3'd1, d);
      total++;
      if (d !== {4'd0, fe_m, ovr_m, 1'b1, rxr_m}) $display("FAIL rx_random_sr[%0d]: got %h expected %h", n, d, {4'd0, fe_m, ovr_m, 1'b1, rxr_m});
      else passed++;
    end
    b = 8'($urandom);
    rxd = 1'b0;
    repeat (8) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      rxd = b[k];
      repeat (8) @(negedge clk);
    end
    bus_write(3'd0, 8'h00);
    for (int k = 4; k < 8; k++) begin
      rxd = b[k];
      repeat (8) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (16) @(negedge clk);
    bus_write(3'd0, 8'h01);
    repeat (8) @(negedge clk);
    bus_read(3'd1, d);
    total++;
    if (d !== {4'd0, fe_m, ovr_m, 1'b1, rxr_m}) $display("FAIL rx_disable_sr: got %h expected %h", d, {4'd0, fe_m, ovr_m, 1'b1, rxr_m});
    else passed++;
    peek(3'd4, d);
    total++;
    if (d !== di_m) $display("FAIL rx_disable_di: got %h expected %h", d, di_m); else passed++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_regs;
    test_tx_frame(8'h48);
    test_tx_frame(8'($urandom));
    test_back_to_back;
    test_reset_mid_tx;
    test_rx;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
